sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Sequences the MEM-stage data memory access onto an external 16-bit asynchronous SRAM. One 32-bit word is transferred as two half-word phases, each with programmable wait states.
- Sits between the EXE→MEM pipeline outputs and the MEM-stage pipeline register.
- Its `ready` output is the `memReady` stall input of every pipeline register. While `ready` is low, the whole pipeline freezes.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 1, extra cycles held per half-word phase; legal range 0..15.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  load request from EXE stage (mem_r_en).
- wr_en  input  1  store request from EXE stage (mem_w_en).
- address  input  32  CPU byte address (alu_result).
- write_data  input  32  store data.
- read_data  output  32  load data; valid in the DONE cycle and held afterwards.
- ready  output  1  high = no access outstanding; drives memReady.
- sram_addr  output  ADDR_W  SRAM half-word address.
- sram_dq_in  input  16  SRAM data bus, read side.
- sram_dq_out  output  16  SRAM data bus, write side.
- sram_dq_oe  output  1  high = controller drives the bus.
- sram_we_n  output  1  SRAM write strobe, active low.
- sram_oe_n  output  1  SRAM output enable, active low.

Behaviour:
- Reset values (rst low; effect is immediate):
  - state IDLE, phase counter 0.
  - read_data = 0; latched address and data = 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
- ready is combinational: ready = !((rd_en | wr_en) & state != DONE).
  - ready therefore drops in the same cycle a request appears in IDLE.
  - ready is high in IDLE when no request is present.
  - During reset, state is IDLE and ready follows the same formula.
- Request selection: wr_en has priority. If rd_en and wr_en are both high, the access is a write.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated to ADDR_W-1 bits. Two's-complement wrap applies and there is no range check.
  - Low half-word address = {word, 1'b0}; high half-word address = {word, 1'b1}.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - With a request present: latch the mapped word, write_data and op type, then go to LO.
  - With no request: stay in IDLE.
  - SRAM strobes are inactive.
- LO: lasts WAIT_CYCLES+1 cycles (counter 0..WAIT_CYCLES); sram_addr = low half-word address.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = data[15:0].
  - Read: sram_oe_n = 0; read_data[15:0] <= sram_dq_in on the final LO cycle.
  - The counter clears on exit to HI.
- HI: identical to LO but uses the high half-word address and data[31:16]. Exits to DONE.
- DONE: strobes inactive, ready = 1, go to IDLE next cycle.
  - The pipeline register captures at this edge, so the request seen afterwards belongs to the next instruction.
- Latency, requests only: ready is low for 2*WAIT_CYCLES+3 consecutive cycles and high in the following (DONE) cycle.
  - WAIT_CYCLES=1 gives 5 stall cycles.
  - WAIT_CYCLES=0 gives 3 stall cycles.
- Back-to-back accesses: a request present in the IDLE cycle after DONE starts a new access immediately. There is no bubble beyond DONE→IDLE.
- read_data holds its last value across writes and idle periods; it is updated only by read phases.
- Request deasserted mid-access: this is illegal while ready is low. The FSM completes the latched access regardless.
- Strobes are never asserted in IDLE or DONE. sram_we_n and sram_oe_n are never low in the same cycle.
- Reset mid-access: the FSM returns to IDLE asynchronously, strobes deassert, and the partial read_data is cleared to 0.

Test Plan:
- Read, WAIT_CYCLES=1: SRAM half-word 0 = 16'hBEEF, half-word 1 = 16'hDEAD; rd_en=1, address=1024 → ready low 5 cycles; sram_addr 0 for 2 cycles, then 1 for 2 cycles; DONE cycle ready=1, read_data=32'hDEADBEEF.
- Write then read-back: wr_en=1, address=1032, write_data=32'h12345678 → sram_addr 4 with dq_out 16'h5678 and we_n=0 for 2 cycles, then sram_addr 5 with 16'h1234. A following read of 1032 returns 32'h12345678.
- WAIT_CYCLES=0: read at 1028 → ready low exactly 3 cycles; sram_addr 2 for 1 cycle, then 3; data correct.
- Back-to-back: read at 1024 immediately followed by write at 1028 → second access enters LO one cycle after the first's DONE; read_data unchanged by the write.
- Simultaneous rd_en=wr_en=1 → write strobes only, oe_n stays 1. Idle with no requests → ready=1, all strobes inactive.
- Reset mid-HI of a read → asynchronously state IDLE, strobes inactive, read_data=0. After release with no request, ready=1.

Source files
------------

// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two
// half-word phases (low half, then high half), each held for WAIT_CYCLES+1 cycles.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   rd_en, wr_en      load/store request from EXE (store wins when both are high)
//   address           CPU byte address; BASE_ADDR maps to SRAM word 0
//   write_data        store data
//   read_data         load data, valid in the DONE cycle and held until the next load
//   ready             low while a request is outstanding; freezes the pipeline
//   sram_addr         SRAM half-word address
//   sram_dq_in        SRAM data bus, read side
//   sram_dq_out       SRAM data bus, write side
//   sram_dq_oe        high while the controller drives the data bus
//   sram_we_n         SRAM write strobe, active low
//   sram_oe_n         SRAM output enable, active low
module sram_mem_controller #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLo   = 2'd1;
    localparam logic [1:0] StHi   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    logic [1:0]        state_d, state_q;
    logic [3:0]        cnt_d, cnt_q;
    logic [ADDR_W-2:0] word_d, word_q;
    logic [31:0]       data_d, data_q;
    logic              wr_d, wr_q;
    logic [31:0]       rdata_d, rdata_q;

    logic phase_last;
    logic in_phase;
    logic hi_phase;

    assign phase_last = (cnt_q == WaitLast);
    assign in_phase   = (state_q == StLo) || (state_q == StHi);
    assign hi_phase   = (state_q == StHi);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (rd_en || wr_en) begin
                    // Out-of-range addresses simply wrap onto the SRAM.
                    word_d  = (ADDR_W-1)'((address - BASE_ADDR) >> 2);
                    data_d  = write_data;
                    wr_d    = wr_en;
                    cnt_d   = 4'd0;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = StHi;
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHi: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = StDone;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                // The pipeline register captures at this edge, so any request seen in
                // the following IDLE cycle is the next instruction's.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            word_q  <= '0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode only from registered state, so they are inactive outside LO/HI
    // and we_n/oe_n can never be low together.
    always_comb begin
        ready       = !((rd_en || wr_en) && (state_q != StDone));
        read_data   = rdata_q;
        sram_addr   = in_phase ? {word_q, hi_phase} : '0;
        sram_we_n   = !(in_phase && wr_q);
        sram_oe_n   = !(in_phase && !wr_q);
        sram_dq_oe  = in_phase && wr_q;
        sram_dq_out = 16'd0;
        if (in_phase && wr_q) begin
            sram_dq_out = hi_phase ? data_q[31:16] : data_q[15:0];
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

    typedef struct {
        logic [17:0] addr;
        logic        wr;
        logic [15:0] dq;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        int          stall;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    beat_t beat_q[$];
    done_t done_q[$];

    // DUT with WAIT_CYCLES=1 (scoreboarded)
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = 32'd0, write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    // DUT with WAIT_CYCLES=0
    logic        rd1 = 1'b0;
    logic [31:0] addr1 = 32'd0;
    logic [31:0] rdata1;
    logic        ready1;
    logic [17:0] saddr1;
    logic [15:0] dqin1, dqout1;
    logic        dqoe1, we1_n, oe1_n;

    sram_mem_controller #(.ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_mem_controller #(.ADDR_W(18), .WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut_w0 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(1'b0), .address(addr1),
        .write_data(32'd0), .read_data(rdata1), .ready(ready1),
        .sram_addr(saddr1), .sram_dq_in(dqin1), .sram_dq_out(dqout1),
        .sram_dq_oe(dqoe1), .sram_we_n(we1_n), .sram_oe_n(oe1_n)
    );

    // Simple SRAM models
    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= 16'd0;
                mem1[i] <= 16'd0;
            end
            mem0[0] <= 16'hBEEF;
            mem0[1] <= 16'hDEAD;
            mem1[2] <= 16'h3344;
            mem1[3] <= 16'h1122;
        end else begin
            if (!sram_we_n) mem0[sram_addr[5:0]] <= sram_dq_out;
            if (!we1_n) mem1[saddr1[5:0]] <= dqout1;
        end
    end

    assign sram_dq_in = mem0[sram_addr[5:0]];
    assign dqin1      = mem1[saddr1[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected SRAM beats and access completions as the DUT shows them.
    int stall = 0;
    always @(negedge clk) begin
        if (!rst) begin
            stall = 0;
        end else begin
            chk("strobe_excl", {31'd0, sram_we_n | sram_oe_n}, 32'd1);
            if (!sram_we_n || !sram_oe_n) begin
                if (beat_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got addr %h, expected no strobe",
                             sram_addr);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", 32'(sram_addr), 32'(b.addr));
                    chk("beat_we_n", {31'd0, sram_we_n}, {31'd0, !b.wr});
                    chk("beat_oe_n", {31'd0, sram_oe_n}, {31'd0, b.wr});
                    chk("beat_dq_oe", {31'd0, sram_dq_oe}, {31'd0, b.wr});
                    if (b.wr) chk("beat_dq_out", 32'(sram_dq_out), 32'(b.dq));
                end
            end
            if (rd_en || wr_en) begin
                if (!ready) begin
                    stall++;
                end else if (stall > 0) begin
                    if (done_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got read_data %h, expected none",
                                 read_data);
                    end else begin
                        done_t d;
                        d = done_q.pop_front();
                        chk("stall_cycles", 32'(stall), 32'(d.stall));
                        chk("read_data", read_data, d.rdata);
                    end
                    stall = 0;
                end
            end else begin
                chk("idle_ready", {31'd0, ready}, 32'd1);
            end
        end
    end

    task automatic push_beats(input logic wr, input logic [17:0] lo, input logic [31:0] d);
        for (int i = 0; i < 2; i++) beat_q.push_back('{addr: lo, wr: wr, dq: d[15:0]});
        for (int i = 0; i < 2; i++) beat_q.push_back('{addr: lo | 18'd1, wr: wr, dq: d[31:16]});
    endtask

    // Issues one access, holds it until the DONE cycle, then returns just after the DONE
    // edge. keep=1 leaves the request up so the caller can chain the next one.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [17:0] lo,
                          input logic [31:0] exp_rd, input bit keep);
        bit done = 0;
        push_beats(wr, lo, wd);
        done_q.push_back('{rdata: exp_rd, stall: 5});
        wr_en = wr;
        rd_en = rd;
        address = a;
        write_data = wd;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    task automatic test_w0();
        int          st = 0;
        logic [17:0] seen[$];
        rd1 = 1'b1;
        addr1 = 32'd1028;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!oe1_n) seen.push_back(saddr1);
            if (ready1) break;
            st++;
        end
        chk("w0_stall", 32'(st), 32'd3);
        chk("w0_beats", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("w0_addr_lo", 32'(seen[0]), 32'd2);
            chk("w0_addr_hi", 32'(seen[1]), 32'd3);
        end
        chk("w0_read_data", rdata1, 32'h11223344);
        @(posedge clk);
        #1;
        rd1 = 1'b0;
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Idle with no request
        repeat (3) @(negedge clk);
        chk("idle_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 32'd1024, 32'd0,           18'd0, 32'hDEADBEEF, 0);
        access(1'b1, 1'b0, 32'd1032, 32'h12345678,    18'd4, 32'hDEADBEEF, 0);
        access(1'b0, 1'b1, 32'd1032, 32'd0,           18'd4, 32'h12345678, 0);
        // Back-to-back read then write
        access(1'b0, 1'b1, 32'd1024, 32'd0,           18'd0, 32'hDEADBEEF, 1);
        access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D,    18'd2, 32'hDEADBEEF, 0);
        // Simultaneous rd_en/wr_en is a write
        access(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A,    18'd6, 32'hDEADBEEF, 0);
        access(1'b0, 1'b1, 32'd1036, 32'd0,           18'd6, 32'hA5A55A5A, 0);
        access(1'b0, 1'b1, 32'd1028, 32'd0,           18'd2, 32'hCAFEF00D, 0);

        test_w0();

        // Reset in the second HI cycle of a read: LO, LO and one HI beat are expected
        for (int i = 0; i < 2; i++) beat_q.push_back('{addr: 18'd0, wr: 1'b0, dq: 16'd0});
        beat_q.push_back('{addr: 18'd1, wr: 1'b0, dq: 16'd0});
        rd_en = 1'b1;
        address = 32'd1024;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("mid_rst_read_data", read_data, 32'd0);
        chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("mid_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("mid_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_read_data", read_data, 32'd0);

        chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
